rx_frame_reader: RTL
====================

# rx_frame_reader

Drains completed frames from the receiver's frame buffer and streams them to the host side as a byte stream with a valid/ready handshake. Sits directly downstream of `rx`: watches its event bus, reads the 128-byte RX buffer through its read port, and emits `sync, length, payload[1..L], status` per frame. Protects host framing against buffer overwrite and missed frames.

## Interface
- `SYNC_BYTE`, 8'hA5: first byte of every emitted frame.
- `clk`  in  1  system clock, single clock domain.
- `reset`  in  1  synchronous, active-high; everything in the block is reset by it.
- `i_enable`  in  1  1 = accept new frames; 0 = ignore END events (a frame in progress still completes).
- `i_rx_ev`  in  3  event code from `rx` (`RX_EVENT_*` from `rx.vh`).
- `i_rx_ev_sig`  in  1  event strobe from `rx`.
- `i_rx_fcs_ok`  in  1  FCS status from `rx`; sampled with the END event.
- `o_buf_r_addr`  out  7  RX buffer read address, registered.
- `i_buf_r_byte`  in  8  RX buffer read data; valid the cycle after the edge that samples `o_buf_r_addr`, i.e. a 1-cycle synchronous read.
- `o_tx_byte`  out  8  stream data, registered.
- `o_tx_valid`  out  1  stream valid, registered.
- `i_tx_ready`  in  1  host ready; a byte transfers at a clock edge where valid and ready are both 1.
- `o_busy`  out  1  frame being streamed.
- `o_drop_cnt`  out  8  saturating count of END events lost while busy or disabled.

## Operation
- Reset values:
  - `o_buf_r_addr` = 0, `o_tx_byte` = 0, `o_tx_valid` = 0, `o_busy` = 0, `o_drop_cnt` = 0.
  - FSM in IDLE; internal flags cleared.
- New-event detect:
  - A new event is `i_rx_ev_sig` = 1 AND (`i_rx_ev_sig` was 0 on the previous cycle, OR `i_rx_ev` differs from its previous-cycle value).
  - The registered copies of sig and ev are reset to 0.
- FSM states: IDLE, SYNC, LEN, DATA, STAT.
  - IDLE: on a new END event with `i_enable` = 1:
    - latch fcs_ok;
    - clear the overrun and clamp flags;
    - `o_buf_r_addr` <= 0, `o_tx_byte` <= SYNC_BYTE, `o_tx_valid` <= 1, `o_busy` <= 1;
    - go to SYNC.
  - SYNC accepted -> LEN.
  - LEN:
    - The byte is the clamped length: `L = min(buf[0], 127)`. If `buf[0]` > 127, set the clamp flag.
    - When LEN becomes valid, set `o_buf_r_addr` <= 1.
    - On accept: if L = 0 -> STAT, else -> DATA with index k = 1.
  - DATA: byte k = `buf[k]`.
    - When byte k becomes valid, set `o_buf_r_addr` <= k+1 (prefetch; 7-bit wrap is harmless because k ≤ 127).
    - On accept: k = L -> STAT, else k <= k+1.
  - STAT:
    - Byte = {fcs_ok, 5'b0, overrun, clamp}.
    - On accept: `o_busy` <= 0 on the same edge -> IDLE.
- Byte pacing:
  - After each accepted byte, `o_tx_valid` is 0 for exactly one cycle.
  - On the following edge, the next byte is loaded from `i_buf_r_byte` (LEN/DATA) or from internal state (STAT), and `o_tx_valid` is set to 1.
- Handshake rules:
  - While `o_tx_valid` = 1 and `i_tx_ready` = 0, `o_tx_byte` and `o_tx_valid` hold.
  - `o_buf_r_addr` holds during the stall as well.
- Overrun: a new PHR or SFD event while `o_busy` = 1 sets the overrun flag. Streaming continues unchanged, so framing is kept even though the data may be corrupt.
- Drops:
  - A new END event while busy, or while IDLE with `i_enable` = 0, increments `o_drop_cnt`, saturating at 255.
  - An END detected in the same cycle as the STAT accept counts as busy, so it is dropped.
- `i_enable` falling mid-frame: no effect on the current frame.
- Reset mid-frame: on the next edge, return to the reset values immediately. No status byte is emitted.

## Timing
- E0 = the edge that detects the END event.
- With `i_tx_ready` held at 1:
  - SYNC valid after E0, accepted at E1.
  - LEN valid after E2, accepted at E3.
  - Payload byte k valid after E(2k+2).
  - STAT valid after E(2L+4), accepted at E(2L+5).
  - `o_busy` = 0 after E(2L+5).
- Frame length on the stream: L+3 bytes. Throughput: 1 byte per 2 cycles.
- Length data is read from address 0, which is set at E0 and sampled by the RAM at E1; `i_buf_r_byte` is used at E2.
- The earliest new frame: an END detected at E(2L+6).

## Test plan
- buf[0]=3, buf[1..3]=11,22,33, END with fcs_ok=1, ready=1 -> stream A5,03,11,22,33,80. The stream is 6 bytes; `o_busy` is high for 11 cycles.
- Same frame with ready toggling 0/1 every cycle plus a random 5-cycle stall -> identical bytes. No byte is dropped or duplicated, and `o_tx_byte` is stable during stalls.
- buf[0]=0, fcs_ok=0 -> A5,00,00.
- buf[0]=200 -> LEN byte 7F, then payload buf[1..127], then status 01.
- PHR event injected during DATA -> status byte has bit1 set. A second END while busy -> `o_drop_cnt` = 1 and no second frame is started.
- `i_enable` = 0 with an END -> no output and `o_drop_cnt` += 1. Reset asserted during DATA -> `o_tx_valid` = 0, `o_busy` = 0, `o_buf_r_addr` = 0 after the next edge; a following END yields a clean A5 frame.

Source files
------------

// File: rtl/rx_frame_reader.sv
// Drains completed frames from the 128-byte RX buffer and streams them to the host
// as sync, length, payload[1..L], status over a valid/ready byte handshake.
module rx_frame_reader #(
    parameter logic [7:0] SYNC_BYTE    = 8'hA5,
    // Event encoding shared with the rx block's event bus
    parameter logic [2:0] RX_EVENT_SFD = 3'd1,
    parameter logic [2:0] RX_EVENT_PHR = 3'd2,
    parameter logic [2:0] RX_EVENT_END = 3'd3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_enable,
    input  logic [2:0] i_rx_ev,
    input  logic       i_rx_ev_sig,
    input  logic       i_rx_fcs_ok,
    output logic [6:0] o_buf_r_addr,
    input  logic [7:0] i_buf_r_byte,
    output logic [7:0] o_tx_byte,
    output logic       o_tx_valid,
    input  logic       i_tx_ready,
    output logic       o_busy,
    output logic [7:0] o_drop_cnt
);

    typedef enum logic [2:0] {S_IDLE, S_SYNC, S_LEN, S_DATA, S_STAT} state_t;

    state_t     r_state;
    logic [6:0] r_buf_r_addr;
    logic [7:0] r_tx_byte;
    logic       r_tx_valid;
    logic       r_busy;
    logic [7:0] r_drop_cnt;
    logic       r_fcs_ok;
    logic       r_overrun;
    logic       r_clamp;
    logic [6:0] r_len;
    logic [6:0] r_k;
    logic       r_sig_prev;
    logic [2:0] r_ev_prev;

    logic       w_new_ev;
    logic       w_end_ev;
    logic       w_hdr_ev;
    logic [6:0] w_len_clamped;

    // A held strobe only counts again if the event code changes
    assign w_new_ev      = i_rx_ev_sig && (!r_sig_prev || (i_rx_ev != r_ev_prev));
    assign w_end_ev      = w_new_ev && (i_rx_ev == RX_EVENT_END);
    assign w_hdr_ev      = w_new_ev && ((i_rx_ev == RX_EVENT_PHR) || (i_rx_ev == RX_EVENT_SFD));
    assign w_len_clamped = i_buf_r_byte[7] ? 7'd127 : i_buf_r_byte[6:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_buf_r_addr <= 7'd0;
            r_tx_byte    <= 8'd0;
            r_tx_valid   <= 1'b0;
            r_busy       <= 1'b0;
            r_drop_cnt   <= 8'd0;
            r_fcs_ok     <= 1'b0;
            r_overrun    <= 1'b0;
            r_clamp      <= 1'b0;
            r_len        <= 7'd0;
            r_k          <= 7'd0;
            r_sig_prev   <= 1'b0;
            r_ev_prev    <= 3'd0;
        end else begin
            r_sig_prev <= i_rx_ev_sig;
            r_ev_prev  <= i_rx_ev;

            if (w_end_ev && (r_busy || !i_enable) && (r_drop_cnt != 8'hFF))
                r_drop_cnt <= r_drop_cnt + 8'd1;
            if (w_hdr_ev && r_busy)
                r_overrun <= 1'b1;

            // Each byte after SYNC has a load cycle (valid low) then a hold-until-accept phase
            case (r_state)
                S_IDLE: begin
                    if (w_end_ev && i_enable) begin
                        r_fcs_ok     <= i_rx_fcs_ok;
                        r_overrun    <= 1'b0;
                        r_clamp      <= 1'b0;
                        r_buf_r_addr <= 7'd0;
                        r_tx_byte    <= SYNC_BYTE;
                        r_tx_valid   <= 1'b1;
                        r_busy       <= 1'b1;
                        r_state      <= S_SYNC;
                    end
                end
                S_SYNC: begin
                    if (r_tx_valid && i_tx_ready) begin
                        r_tx_valid <= 1'b0;
                        r_state    <= S_LEN;
                    end
                end
                S_LEN: begin
                    if (!r_tx_valid) begin
                        r_tx_byte    <= {1'b0, w_len_clamped};
                        r_len        <= w_len_clamped;
                        r_clamp      <= i_buf_r_byte[7];
                        r_tx_valid   <= 1'b1;
                        r_buf_r_addr <= 7'd1;
                    end else if (i_tx_ready) begin
                        r_tx_valid <= 1'b0;
                        r_k        <= 7'd1;
                        r_state    <= (r_len == 7'd0) ? S_STAT : S_DATA;
                    end
                end
                S_DATA: begin
                    if (!r_tx_valid) begin
                        r_tx_byte    <= i_buf_r_byte;
                        r_tx_valid   <= 1'b1;
                        r_buf_r_addr <= r_k + 7'd1;
                    end else if (i_tx_ready) begin
                        r_tx_valid <= 1'b0;
                        if (r_k == r_len)
                            r_state <= S_STAT;
                        else
                            r_k <= r_k + 7'd1;
                    end
                end
                S_STAT: begin
                    if (!r_tx_valid) begin
                        r_tx_byte  <= {r_fcs_ok, 5'b00000, r_overrun, r_clamp};
                        r_tx_valid <= 1'b1;
                    end else if (i_tx_ready) begin
                        r_tx_valid <= 1'b0;
                        r_busy     <= 1'b0;
                        r_state    <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_buf_r_addr = r_buf_r_addr;
    assign o_tx_byte    = r_tx_byte;
    assign o_tx_valid   = r_tx_valid;
    assign o_busy       = r_busy;
    assign o_drop_cnt   = r_drop_cnt;

endmodule
